// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle FSM sequencer for the 24-bit CPU.
// It drives the datapath strobes and ALU control, has a memory stall timeout, and traps illegal encodings.
module multicycle_control #(
    parameter int OPCODE_W    = 4,
    parameter int FUNCT_W     = 4,
    parameter int ALUCTL_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                branch_ne,
    output logic [1:0]          pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTL_W-1:0] alu_ctl,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                instr_done,
    output logic                fault,
    output logic [1:0]          fault_code
);
    localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(8);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(0);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(1);
    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(2);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(6);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(7);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT} state_t;

    state_t state, state_next;
    logic [OPCODE_W-1:0] op_q;
    logic [FUNCT_W-1:0]  fn_q;
    logic [CW-1:0]       cnt;
    logic [1:0]          code_q, code_next;
    logic [ALUCTL_W-1:0] r_ctl;
    logic timeout, legal, is_br;

    // cnt holds the number of low cycles already spent, so the MEM_TIMEOUT-th low cycle sees LIMIT
    assign timeout = MEM_TIMEOUT != 0 && !mem_ready && cnt == LIMIT;
    assign legal = opcode == OP_R ? funct <= FUNCT_W'(4)
                 : opcode inside {OP_ADDI, OP_ANDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
    assign is_br = op_q == OP_BEQ || op_q == OP_BNE;
    assign r_ctl = fn_q == FUNCT_W'(0) ? ALU_AND
                 : fn_q == FUNCT_W'(1) ? ALU_OR
                 : fn_q == FUNCT_W'(2) ? ALU_ADD
                 : fn_q == FUNCT_W'(3) ? ALU_SUB : ALU_SLT;
    assign fault_code = code_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            fn_q   <= '0;
            code_q <= 2'b00;
        end else begin
            state <= state_next;
            cnt   <= state_next != state ? '0
                   : ((state == FETCH || state == MEM) && !mem_ready && cnt != '1) ? cnt + 1'b1 : cnt;
            if (state == DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (state_next == FAULT && state != FAULT)
                code_q <= code_next;
        end
    end

    always_comb begin
        state_next = state;
        code_next  = 2'b00;
        case (state)
            IDLE:   state_next = FETCH;
            FETCH: begin
                state_next = mem_ready ? DECODE : timeout ? FAULT : FETCH;
                code_next  = 2'b10;
            end
            DECODE: begin
                state_next = legal ? EXEC : FAULT;
                code_next  = 2'b01;
            end
            EXEC:   state_next = (op_q == OP_LW || op_q == OP_SW) ? MEM
                               : (op_q inside {OP_R, OP_ADDI, OP_ANDI}) ? WB : FETCH;
            MEM: begin
                state_next = mem_ready ? (op_q == OP_LW ? WB : FETCH) : timeout ? FAULT : MEM;
                code_next  = 2'b10;
            end
            WB:     state_next = FETCH;
            FAULT:  state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_ctl       = ALU_AND;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        instr_done    = 1'b0;
        fault         = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctl   = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_ctl   = ALU_ADD;
            end
            EXEC: begin
                if (op_q == OP_J) begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end else begin
                    alu_src_a     = 1'b1;
                    alu_src_b     = (op_q == OP_R || is_br) ? 2'b00 : 2'b10;
                    alu_ctl       = op_q == OP_R ? r_ctl : op_q == OP_ANDI ? ALU_AND : is_br ? ALU_SUB : ALU_ADD;
                    pc_write_cond = is_br;
                    pc_source     = is_br ? 2'b01 : 2'b00;
                    branch_ne     = op_q == OP_BNE;
                    instr_done    = is_br;
                end
            end
            MEM: begin
                i_or_d     = 1'b1;
                mem_read   = op_q == OP_LW;
                mem_write  = op_q == OP_SW;
                instr_done = mem_ready && op_q == OP_SW;
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = op_q == OP_R;
                mem_to_reg = op_q == OP_LW;
                instr_done = 1'b1;
            end
            FAULT: fault = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for the multi-cycle control FSM.
// Each scenario queues per-cycle inputs and expected outputs, then replays and checks them.
module tb_multicycle_control;
    logic clk = 1'b0, rst;
    logic [3:0] opcode, funct;
    logic mem_ready;
    logic ir_write, pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, alu_src_a;
    logic reg_write, reg_dst, mem_to_reg, instr_done, fault;
    logic [1:0] pc_source, alu_src_b, fault_code;
    logic [3:0] alu_ctl;

    typedef struct packed {
        logic ir_write, pc_write, pc_write_cond, branch_ne;
        logic [1:0] pc_source;
        logic i_or_d, mem_read, mem_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
        logic reg_write, reg_dst, mem_to_reg, instr_done, fault;
        logic [1:0] fault_code;
    } outs_t;

    typedef struct {
        logic [3:0] op, fn;
        logic       rdy;
        outs_t      o;
    } ent_t;

    outs_t act;
    ent_t sb[$];
    int checks = 0, passed = 0;

    assign act = {ir_write, pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
                  alu_src_a, alu_src_b, alu_ctl, reg_write, reg_dst, mem_to_reg, instr_done, fault, fault_code};

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done), .fault(fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic outs_t m_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_ctl = 4'b0010;
        o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction

    function automatic outs_t m_decode();
        outs_t o = '0;
        o.alu_src_b = 2'b11; o.alu_ctl = 4'b0010;
        return o;
    endfunction

    function automatic outs_t m_exec(input logic [3:0] op, input logic [3:0] fn);
        outs_t o = '0;
        case (op)
            4'd0: begin
                o.alu_src_a = 1'b1;
                case (fn)
                    4'd0: o.alu_ctl = 4'b0000;
                    4'd1: o.alu_ctl = 4'b0001;
                    4'd2: o.alu_ctl = 4'b0010;
                    4'd3: o.alu_ctl = 4'b0110;
                    default: o.alu_ctl = 4'b0111;
                endcase
            end
            4'd1, 4'd4, 4'd5: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctl = 4'b0010; end
            4'd2: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctl = 4'b0000; end
            4'd6, 4'd7: begin
                o.alu_src_a = 1'b1; o.alu_ctl = 4'b0110; o.pc_write_cond = 1'b1;
                o.pc_source = 2'b01; o.branch_ne = op == 4'd7; o.instr_done = 1'b1;
            end
            default: begin o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1; end
        endcase
        return o;
    endfunction

    function automatic outs_t m_mem(input logic [3:0] op, input logic rdy);
        outs_t o = '0;
        o.i_or_d = 1'b1; o.mem_read = op == 4'd4; o.mem_write = op == 4'd5;
        o.instr_done = rdy && op == 4'd5;
        return o;
    endfunction

    function automatic outs_t m_wb(input logic [3:0] op);
        outs_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = op == 4'd0; o.mem_to_reg = op == 4'd4; o.instr_done = 1'b1;
        return o;
    endfunction

    function automatic outs_t m_fault(input logic [1:0] code);
        outs_t o = '0;
        o.fault = 1'b1; o.fault_code = code;
        return o;
    endfunction

    task automatic push(input logic [3:0] op, input logic [3:0] fn, input logic rdy, input outs_t o);
        ent_t e;
        e.op = op; e.fn = fn; e.rdy = rdy; e.o = o;
        sb.push_back(e);
    endtask

    task automatic push_front_half(input logic [3:0] op, input logic [3:0] fn, input int fw);
        for (int i = 0; i < fw; i++) push(op, fn, 1'b0, m_fetch(1'b0));
        push(op, fn, 1'b1, m_fetch(1'b1));
        push(op, fn, 1'b1, m_decode());
        push(op, fn, 1'b1, m_exec(op, fn));
    endtask

    task automatic push_instr(input logic [3:0] op, input logic [3:0] fn, input int fw, input int mw);
        push_front_half(op, fn, fw);
        if (op == 4'd4 || op == 4'd5) begin
            for (int i = 0; i < mw; i++) push(op, fn, 1'b0, m_mem(op, 1'b0));
            push(op, fn, 1'b1, m_mem(op, 1'b1));
        end
        if (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd4) push(op, fn, 1'b1, m_wb(op));
    endtask

    // Reset lands on a falling edge; the cycle right after release is IDLE.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; opcode = 4'd0; funct = 4'd0;
        @(negedge clk);
        rst = 1'b0;
        push(4'd0, 4'd0, 1'b1, '0);
    endtask

    task automatic test_reset();
        ent_t e;
        int n = 0;
        #1;
        checks++;
        if (act !== outs_t'('0)) $display("FAIL reset_async: got %h expected %h", act, outs_t'('0));
        else passed++;
        do_reset();
        push_instr(4'd0, 4'd2, 2, 0);
        push(4'd0, 4'd0, 1'b0, m_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; mem_ready = e.rdy; #1;
            checks++;
            if (act !== e.o) $display("FAIL reset_add step %0d: got %h expected %h", n, act, e.o);
            else passed++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        int n = 0;
        do_reset();
        for (int f = 0; f < 5; f++) push_instr(4'd0, 4'(f), 0, 0);
        push_instr(4'd1, 4'd9, 0, 0);
        push_instr(4'd2, 4'd0, 1, 0);
        push_instr(4'd6, 4'd0, 0, 0);
        push_instr(4'd7, 4'd0, 0, 0);
        push_instr(4'd8, 4'd0, 0, 0);
        push(4'd0, 4'd0, 1'b0, m_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; mem_ready = e.rdy; #1;
            checks++;
            if (act !== e.o) $display("FAIL back_to_back step %0d: got %h expected %h", n, act, e.o);
            else passed++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_mem_access();
        ent_t e;
        int n = 0;
        do_reset();
        push_instr(4'd4, 4'd0, 0, 3);
        push_instr(4'd5, 4'd3, 0, 2);
        push_instr(4'd4, 4'd0, 14, 14);
        push_instr(4'd5, 4'd0, 0, 0);
        push(4'd0, 4'd0, 1'b0, m_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; mem_ready = e.rdy; #1;
            checks++;
            if (act !== e.o) $display("FAIL mem_access step %0d: got %h expected %h", n, act, e.o);
            else passed++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        ent_t e;
        int n = 0;
        logic [3:0] ops [3] = '{4'hF, 4'd0, 4'd3};
        logic [3:0] fns [3] = '{4'd0, 4'd5, 4'd0};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            push(ops[k], fns[k], 1'b1, m_fetch(1'b1));
            push(ops[k], fns[k], 1'b1, m_decode());
            for (int i = 0; i < 21; i++) push(4'(i), 4'(i), 1'($urandom_range(0, 1)), m_fault(2'b01));
            while (sb.size() > 0) begin
                e = sb.pop_front();
                opcode = e.op; funct = e.fn; mem_ready = e.rdy; #1;
                checks++;
                if (act !== e.o) $display("FAIL illegal%0d step %0d: got %h expected %h", k, n, act, e.o);
                else passed++;
                n++;
                @(negedge clk);
            end
            rst = 1'b1; #1;
            checks++;
            if (act !== outs_t'('0)) $display("FAIL illegal_clear%0d: got %h expected %h", k, act, outs_t'('0));
            else passed++;
        end
    endtask

    task automatic test_timeout();
        ent_t e;
        int n = 0;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            if (k == 0) begin
                for (int i = 0; i < 15; i++) push(4'd0, 4'd0, 1'b0, m_fetch(1'b0));
                for (int i = 0; i < 3; i++) push(4'd0, 4'd0, 1'b1, m_fault(2'b10));
            end else if (k == 1) begin
                push_instr(4'd1, 4'd0, 14, 0);
                push(4'd0, 4'd0, 1'b0, m_fetch(1'b0));
            end else begin
                push_front_half(4'd4, 4'd0, 10);
                for (int i = 0; i < 15; i++) push(4'd4, 4'd0, 1'b0, m_mem(4'd4, 1'b0));
                for (int i = 0; i < 3; i++) push(4'd4, 4'd0, 1'b1, m_fault(2'b10));
            end
            while (sb.size() > 0) begin
                e = sb.pop_front();
                opcode = e.op; funct = e.fn; mem_ready = e.rdy; #1;
                checks++;
                if (act !== e.o) $display("FAIL timeout%0d step %0d: got %h expected %h", k, n, act, e.o);
                else passed++;
                n++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        ent_t e;
        int n = 0;
        do_reset();
        push_front_half(4'd5, 4'd0, 0);
        push(4'd5, 4'd0, 1'b0, m_mem(4'd5, 1'b0));
        push(4'd5, 4'd0, 1'b0, m_mem(4'd5, 1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; mem_ready = e.rdy; #1;
            checks++;
            if (act !== e.o) $display("FAIL reset_mid step %0d: got %h expected %h", n, act, e.o);
            else passed++;
            n++;
            @(negedge clk);
        end
        mem_ready = 1'b0; #1;
        checks++;
        if (mem_write !== 1'b1) $display("FAIL reset_mid_pre: mem_write got %b expected 1", mem_write);
        else passed++;
        rst = 1'b1; #1;
        checks++;
        if (act !== outs_t'('0)) $display("FAIL reset_mid_drop: got %h expected %h", act, outs_t'('0));
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        push(4'd0, 4'd0, 1'b1, '0);
        push(4'd0, 4'd0, 1'b0, m_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.op; funct = e.fn; mem_ready = e.rdy; #1;
            checks++;
            if (act !== e.o) $display("FAIL reset_mid_restart step %0d: got %h expected %h", n, act, e.o);
            else passed++;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; opcode = 4'd0; funct = 4'd0;
        test_reset();
        test_back_to_back();
        test_mem_access();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
